// File: rtl/biquad_pkg.sv
// Shared types, widths and rounding/saturation helper for the biquad cascade.
// No clocked logic; sat_round is purely combinational.
package biquad_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_COEFF_W = 32;
  localparam int DEF_FRAC    = 30;
  localparam int NUM_TAPS    = 5;
  localparam int ACC_W       = DEF_COEFF_W + DEF_DATA_W + 3;

  localparam logic [DEF_COEFF_W-1:0] UNITY = DEF_COEFF_W'(64'd1 << DEF_FRAC);

  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;
  typedef enum logic [2:0] {B0, B1, B2, A1, A2} tap_t;

  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(UNITY >> 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (DEF_DATA_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(64'sd1 <<< (DEF_DATA_W-1)));

  // Round half up, drop the fractional bits, clamp to the sample range.
  function automatic logic signed [DEF_DATA_W-1:0] sat_round(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    r = (acc + RND) >>> DEF_FRAC;
    if (r > SAT_HI)
      return SAT_HI[DEF_DATA_W-1:0];
    else if (r < SAT_LO)
      return SAT_LO[DEF_DATA_W-1:0];
    else
      return r[DEF_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/biquad_coeff_ram.sv
// Coefficient preset table: synchronous write, combinational read, reset loads pass-through.
// Read is zero-latency; writes land on the clock edge and are never stalled.
module biquad_coeff_ram
  import biquad_pkg::*;
#(
  parameter int                 COEFF_W  = DEF_COEFF_W,
  parameter int                 DEPTH    = 80,
  parameter int                 AW       = $clog2(DEPTH),
  parameter logic [COEFF_W-1:0] RESET_B0 = UNITY
) (
  input  logic               clk_144,
  input  logic               reset_n,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [COEFF_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [COEFF_W-1:0] rdata
);

  logic [COEFF_W-1:0] mem [DEPTH];

  // Every fifth word is a b0 tap; pass-through means b0 = 1.0, rest 0.
  always_ff @(posedge clk_144) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (i % NUM_TAPS == 0) ? RESET_B0 : '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/biquad_cascade.sv
// Multi-channel DF-I biquad cascade sharing one MAC; 25-cycle latency, one sample per 26 cycles.
// No backpressure: in_ready low while busy, strobes arriving then are dropped and flag overrun.
module biquad_cascade
  import biquad_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int COEFF_W  = DEF_COEFF_W,
  parameter int FRAC     = DEF_FRAC,
  parameter int STAGES   = 2,
  parameter int CHANNELS = 2,
  parameter int NUM_SETS = 8
) (
  input  logic                                       clk_144,
  input  logic                                       reset_n,
  input  logic                                       sample_valid,
  input  logic [CHANNELS*DATA_W-1:0]                 sample_in,
  output logic                                       in_ready,
  input  logic [$clog2(NUM_SETS)-1:0]                filter_sel,
  input  logic                                       coeff_we,
  input  logic [$clog2(NUM_SETS)+$clog2(STAGES)+2:0] coeff_addr,
  input  logic [COEFF_W-1:0]                         coeff_wdata,
  output logic                                       coeff_ack,
  output logic                                       out_valid,
  output logic [CHANNELS*DATA_W-1:0]                 sample_out,
  output logic                                       overrun
);

  localparam int SEL_W = $clog2(NUM_SETS);
  localparam int STG_W = $clog2(STAGES);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NH    = CHANNELS * STAGES;
  localparam int HI_W  = (NH > 1) ? $clog2(NH) : 1;
  localparam int DEPTH = NUM_SETS * STAGES * NUM_TAPS;
  localparam int RA_W  = $clog2(DEPTH);
  localparam int P_W   = COEFF_W + DATA_W;

  state_t                   state_q;
  tap_t                     tap_q;
  logic [STG_W-1:0]         stage_q;
  logic [CH_W-1:0]          chan_q;
  logic [SEL_W-1:0]         set_q, prev_set_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] x_in_q [CHANNELS];
  logic signed [DATA_W-1:0] x1_q [NH];
  logic signed [DATA_W-1:0] x2_q [NH];
  logic signed [DATA_W-1:0] y1_q [NH];
  logic signed [DATA_W-1:0] y2_q [NH];

  logic [SEL_W-1:0]          sel_eff, wr_set;
  logic [STG_W-1:0]          wr_stage;
  logic [2:0]                wr_tap;
  logic                      wr_ok;
  logic [RA_W-1:0]           waddr, raddr;
  logic signed [COEFF_W-1:0] coeff;
  logic [HI_W-1:0]           hidx;
  logic signed [DATA_W-1:0]  x0, operand, result;
  logic signed [P_W-1:0]     prod;
  logic signed [ACC_W-1:0]   acc_base;

  assign in_ready = (state_q == IDLE);
  assign sel_eff  = ({1'b0, filter_sel} >= (SEL_W+1)'(NUM_SETS)) ? '0 : filter_sel;

  assign wr_set   = coeff_addr[STG_W+3 +: SEL_W];
  assign wr_stage = coeff_addr[3 +: STG_W];
  assign wr_tap   = coeff_addr[2:0];
  assign wr_ok    = coeff_we && in_ready && (wr_tap <= A2);
  assign waddr    = RA_W'((int'(wr_set) * STAGES + int'(wr_stage)) * NUM_TAPS + int'(wr_tap));
  assign raddr    = RA_W'((int'(set_q) * STAGES + int'(stage_q)) * NUM_TAPS + int'(tap_q));
  assign hidx     = HI_W'(int'(chan_q) * STAGES + int'(stage_q));

  biquad_coeff_ram #(
    .COEFF_W  (COEFF_W),
    .DEPTH    (DEPTH),
    .AW       (RA_W),
    .RESET_B0 (COEFF_W'(64'd1 << FRAC))
  ) u_coeff_ram (
    .clk_144 (clk_144),
    .reset_n (reset_n),
    .we      (wr_ok),
    .waddr   (waddr),
    .wdata   (coeff_wdata),
    .raddr   (raddr),
    .rdata   (coeff)
  );

  // Later stages take the previous stage's freshly written output as their input.
  always_comb begin
    x0 = x_in_q[chan_q];
    if (stage_q != '0)
      x0 = y1_q[hidx - HI_W'(1)];
    case (tap_q)
      B0:      operand = x0;
      B1:      operand = x1_q[hidx];
      B2:      operand = x2_q[hidx];
      A1:      operand = y1_q[hidx];
      default: operand = y2_q[hidx];
    endcase
  end

  assign prod     = P_W'(coeff) * P_W'(operand);
  assign acc_base = (tap_q == B0) ? '0 : acc_q;
  assign result   = sat_round(acc_q);

  always_ff @(posedge clk_144) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tap_q      <= B0;
      stage_q    <= '0;
      chan_q     <= '0;
      set_q      <= '0;
      prev_set_q <= '0;
      acc_q      <= '0;
      coeff_ack  <= 1'b0;
      out_valid  <= 1'b0;
      sample_out <= '0;
      overrun    <= 1'b0;
      for (int c = 0; c < CHANNELS; c++)
        x_in_q[c] <= '0;
      for (int h = 0; h < NH; h++) begin
        x1_q[h] <= '0;
        x2_q[h] <= '0;
        y1_q[h] <= '0;
        y2_q[h] <= '0;
      end
    end else begin
      coeff_ack <= wr_ok;
      out_valid <= 1'b0;
      if (sample_valid && !in_ready)
        overrun <= 1'b1;
      case (state_q)
        IDLE: begin
          if (sample_valid) begin
            for (int c = 0; c < CHANNELS; c++)
              x_in_q[c] <= sample_in[c*DATA_W +: DATA_W];
            set_q      <= sel_eff;
            prev_set_q <= sel_eff;
            tap_q      <= B0;
            stage_q    <= '0;
            chan_q     <= '0;
            // A preset switch starts from silence so the new filter has no transient.
            if (sel_eff != prev_set_q) begin
              for (int h = 0; h < NH; h++) begin
                x1_q[h] <= '0;
                x2_q[h] <= '0;
                y1_q[h] <= '0;
                y2_q[h] <= '0;
              end
            end
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_base + ACC_W'(prod);
          if (tap_q == A2)
            state_q <= WB;
          else
            tap_q <= tap_t'(tap_q + 3'd1);
        end
        WB: begin
          x2_q[hidx] <= x1_q[hidx];
          x1_q[hidx] <= x0;
          y2_q[hidx] <= y1_q[hidx];
          y1_q[hidx] <= result;
          tap_q      <= B0;
          state_q    <= MAC;
          if (stage_q == STG_W'(STAGES - 1)) begin
            stage_q <= '0;
            if (chan_q == CH_W'(CHANNELS - 1)) begin
              state_q   <= DONE;
              out_valid <= 1'b1;
              for (int c = 0; c < CHANNELS; c++)
                sample_out[c*DATA_W +: DATA_W] <= (c == CHANNELS - 1) ? result
                                                  : y1_q[c*STAGES + STAGES - 1];
            end else begin
              chan_q <= chan_q + CH_W'(1);
            end
          end else begin
            stage_q <= stage_q + STG_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_cascade.sv
// Directed and randomized bench for biquad_cascade against a per-sample arithmetic model.
module tb_biquad_cascade;

  localparam int CH = 2;
  localparam int NS = 8;
  localparam int ONE = 1073741824;

  logic        clk_144 = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [31:0] sample_in;
  logic        in_ready;
  logic [2:0]  filter_sel;
  logic        coeff_we;
  logic [6:0]  coeff_addr;
  logic [31:0] coeff_wdata;
  logic        coeff_ack;
  logic        out_valid;
  logic [31:0] sample_out;
  logic        overrun;

  int tests = 0;
  int fails = 0;

  longint m_coef [NS][2][5];
  longint m_x1 [CH][2];
  longint m_x2 [CH][2];
  longint m_y1 [CH][2];
  longint m_y2 [CH][2];
  int     m_prev;
  int     exp_y [CH];
  int     got_y [CH];

  biquad_cascade dut (
    .clk_144     (clk_144),
    .reset_n     (reset_n),
    .sample_valid(sample_valid),
    .sample_in   (sample_in),
    .in_ready    (in_ready),
    .filter_sel  (filter_sel),
    .coeff_we    (coeff_we),
    .coeff_addr  (coeff_addr),
    .coeff_wdata (coeff_wdata),
    .coeff_ack   (coeff_ack),
    .out_valid   (out_valid),
    .sample_out  (sample_out),
    .overrun     (overrun)
  );

  always #5 clk_144 = ~clk_144;

  task automatic chk(input string tag, input longint obs, input longint expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear_hist();
    for (int c = 0; c < CH; c++)
      for (int s = 0; s < 2; s++) begin
        m_x1[c][s] = 0; m_x2[c][s] = 0; m_y1[c][s] = 0; m_y2[c][s] = 0;
      end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NS; k++)
      for (int s = 0; s < 2; s++)
        for (int t = 0; t < 5; t++)
          m_coef[k][s][t] = (t == 0) ? ONE : 0;
    model_clear_hist();
    m_prev = 0;
  endtask

  task automatic model_step(input int xa, input int xb, input int sel);
    int     eff;
    longint v, acc, r;
    eff = (sel >= NS) ? 0 : sel;
    if (eff != m_prev) model_clear_hist();
    m_prev = eff;
    for (int c = 0; c < CH; c++) begin
      v = (c == 0) ? xa : xb;
      for (int s = 0; s < 2; s++) begin
        acc = m_coef[eff][s][0] * v + m_coef[eff][s][1] * m_x1[c][s] + m_coef[eff][s][2] * m_x2[c][s]
            + m_coef[eff][s][3] * m_y1[c][s] + m_coef[eff][s][4] * m_y2[c][s];
        r = (acc + 536870912) >>> 30;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        m_x2[c][s] = m_x1[c][s]; m_x1[c][s] = v;
        m_y2[c][s] = m_y1[c][s]; m_y1[c][s] = r;
        v = r;
      end
      exp_y[c] = int'(v);
    end
  endtask

  function automatic logic [6:0] mk_addr(input int set, input int stage, input int tap);
    return {3'(set), 1'(stage), 3'(tap)};
  endfunction

  task automatic wr_coef(input int set, input int stage, input int tap, input int val, input bit exp_ack);
    @(negedge clk_144);
    coeff_we = 1'b1; coeff_addr = mk_addr(set, stage, tap); coeff_wdata = val;
    @(posedge clk_144); #1;
    coeff_we = 1'b0;
    chk("coeff_ack", coeff_ack, exp_ack);
    if (exp_ack) m_coef[set][stage][tap] = val;
    @(posedge clk_144); #1;
    chk("coeff_ack_pulse", coeff_ack, 0);
  endtask

  // One accepted sample; optional same-cycle write, late strobe, or write while busy.
  task automatic send(input int xa, input int xb, input int sel, input bit sim_we, input int sim_set,
                      input int sim_tap, input int sim_val, input int extra_at, input int busy_wr_at);
    int got_n;
    bit rdy_leak;
    int extra_outs;
    @(negedge clk_144);
    sample_valid = 1'b1; sample_in = {16'(xb), 16'(xa)}; filter_sel = 3'(sel);
    if (sim_we) begin
      coeff_we = 1'b1; coeff_addr = mk_addr(sim_set, 0, sim_tap); coeff_wdata = sim_val;
      m_coef[sim_set][0][sim_tap] = sim_val;
    end
    @(posedge clk_144); #1;
    sample_valid = 1'b0; coeff_we = 1'b0;
    if (sim_we) chk("sim_write_ack", coeff_ack, 1);
    model_step(xa, xb, sel);
    got_n = 0; rdy_leak = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (busy_wr_at > 0 && n == busy_wr_at + 1) chk("busy_write_ack", coeff_ack, 0);
      if (n == extra_at) sample_valid = 1'b1;
      if (busy_wr_at > 0 && n == busy_wr_at) begin
        coeff_we = 1'b1; coeff_addr = mk_addr(0, 0, 0); coeff_wdata = 0;
      end
      if (in_ready) rdy_leak = 1'b1;
      if (out_valid) begin
        got_n = n;
        break;
      end
      @(posedge clk_144); #1;
      sample_valid = 1'b0; coeff_we = 1'b0;
    end
    chk("latency", got_n, 25);
    chk("busy_in_ready", rdy_leak, 0);
    got_y[0] = int'($signed(sample_out[15:0]));
    got_y[1] = int'($signed(sample_out[31:16]));
    chk("ch0_out", got_y[0], exp_y[0]);
    chk("ch1_out", got_y[1], exp_y[1]);
    @(posedge clk_144); #1;
    chk("out_valid_pulse", out_valid, 0);
    chk("idle_ready", in_ready, 1);
    chk("out_hold", sample_out, {16'(exp_y[1]), 16'(exp_y[0])});
    if (extra_at > 0) begin
      extra_outs = 0;
      for (int n = 0; n < 30; n++) begin
        @(posedge clk_144); #1;
        if (out_valid) extra_outs++;
      end
      chk("dropped_no_output", extra_outs, 0);
      chk("overrun_set", overrun, 1);
    end
  endtask

  task automatic send_s(input int xa, input int xb, input int sel);
    send(xa, xb, sel, 1'b0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0; sample_valid = 1'b0; sample_in = '0; filter_sel = '0;
    coeff_we = 1'b0; coeff_addr = '0; coeff_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk_144);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_coeff_ack", coeff_ack, 0);
    chk("rst_sample_out", sample_out, 0);
    reset_n = 1'b1;

    // Pass-through after reset
    send_s(1000, -2000, 0);
    chk("pass_ch0", got_y[0], 1000);
    chk("pass_ch1", got_y[1], -2000);

    // Gain 0.5 with round-half-up
    wr_coef(1, 0, 0, 536870912, 1'b1);
    send_s(3, -3, 1);
    chk("gain_pos", got_y[0], 2);
    chk("gain_neg", got_y[1], -1);

    // Saturation at 1.5 on both stages
    wr_coef(2, 0, 0, 1610612736, 1'b1);
    wr_coef(2, 1, 0, 1610612736, 1'b1);
    send_s(30000, -30000, 2);
    chk("sat_hi", got_y[0], 32767);
    chk("sat_lo", got_y[1], -32768);

    // Recursion y = x + 0.5*y1
    wr_coef(3, 0, 3, 536870912, 1'b1);
    send_s(1024, -1024, 3);
    chk("rec0", got_y[0], 1024);
    send_s(0, 0, 3);
    chk("rec1", got_y[0], 512);
    send_s(0, 0, 3);
    chk("rec2", got_y[0], 256);
    send_s(0, 0, 3);
    chk("rec3", got_y[0], 128);
    chk("rec3_ch1", got_y[1], -128);

    // Taps 5..7 are not addressable
    wr_coef(0, 0, 5, 12345, 1'b0);
    chk("overrun_still_clear", overrun, 0);

    // Strobe while busy is dropped; write while busy is ignored
    send(700, -800, 0, 1'b0, 0, 0, 0, 5, 3);
    send_s(-1500, 2500, 0);
    chk("set0_intact", got_y[0], -1500);

    // Preset switch clears history; same-cycle write lands first
    wr_coef(4, 0, 1, ONE, 1'b1);
    send_s(100, 10, 4);
    send_s(200, 20, 4);
    chk("fir_hist", got_y[0], 300);
    wr_coef(5, 0, 1, ONE, 1'b1);
    send(200, -40, 5, 1'b1, 5, 0, 805306368, 0, 0);
    chk("switch_clear", got_y[0], 150);
    chk("switch_clear_ch1", got_y[1], -30);
    chk("overrun_sticky", overrun, 1);

    // Random coefficients and samples on sets 6 and 7
    for (int k = 6; k < 8; k++)
      for (int s = 0; s < 2; s++)
        for (int t = 0; t < 5; t++)
          wr_coef(k, s, t, int'($urandom) >>> 2, 1'b1);
    for (int i = 0; i < 16; i++)
      send_s(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
             int'($urandom_range(6, 7)));

    // Reset in the middle of a MAC pass
    @(negedge clk_144);
    sample_valid = 1'b1; sample_in = {16'(77), 16'(88)}; filter_sel = 3'd3;
    @(posedge clk_144); #1;
    sample_valid = 1'b0;
    repeat (2) @(posedge clk_144);
    #1;
    chk("pre_reset_busy", in_ready, 0);
    reset_n = 1'b0;
    @(posedge clk_144); #1;
    reset_n = 1'b1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_overrun", overrun, 0);
    model_reset();
    send_s(1234, -4321, 3);
    chk("post_rst_pass0", got_y[0], 1234);
    chk("post_rst_pass1", got_y[1], -4321);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/biquad_cascade.md
Name: biquad_cascade

Overview:
Time-multiplexed, multi-channel cascade of direct-form-I biquad sections, generalising the single fixed-preset highpass stage. One shared multiply-accumulate unit serves every channel and stage. Coefficients are held in a runtime-writable table of NUM_SETS presets. The block sits between the audio ADC deframer and the EQ/dynamics chain and is driven by the per-sample strobe on clk_144.

Parameters:
DATA_W, 16, sample width (signed)
COEFF_W, 32, coefficient width (signed)
FRAC, 30, coefficient fractional bits; representable range [-2, 2)
STAGES, 2, cascaded biquad sections per channel
CHANNELS, 2, independent audio channels
NUM_SETS, 8, coefficient presets

Ports:
clk_144  in  1  system clock
reset_n  in  1  synchronous active-low reset
sample_valid  in  1  one-cycle strobe; sample_in is valid
sample_in  in  CHANNELS*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
in_ready  out  1  high when IDLE and a sample can be accepted
filter_sel  in  $clog2(NUM_SETS)  preset select, sampled on acceptance
coeff_we  in  1  coefficient write strobe
coeff_addr  in  $clog2(NUM_SETS)+$clog2(STAGES)+3  {set, stage, tap}; tap 0..4 = b0,b1,b2,a1,a2
coeff_wdata  in  COEFF_W  coefficient value
coeff_ack  out  1  one-cycle pulse, cycle after an accepted write
out_valid  out  1  one-cycle pulse; sample_out valid
sample_out  out  CHANNELS*DATA_W  filtered samples, same packing as sample_in
overrun  out  1  sticky; set when sample_valid arrives while busy

Behaviour:
- Reset (reset_n low at a clock edge): every output is 0 except in_ready = 1. History is cleared, FSM goes to IDLE, and any in-progress sample is abandoned. Every coefficient set is reset to pass-through: b0 = 2^FRAC, all other taps 0.
- Difference equation: y = b0*x0 + b1*x1 + b2*x2 + a1*y1 + a2*y2. The a-terms are stored already negated.
- Arithmetic: products are COEFF_W+DATA_W bits, accumulated at ACC_W = COEFF_W+DATA_W+3.
- Stage result: add 2^(FRAC-1) to the accumulator, arithmetic-shift right by FRAC, then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- The saturated result feeds the next stage's x0 and is stored as that stage's y1.
- FSM states:
  - IDLE: in_ready = 1. On sample_valid, latch sample_in and filter_sel, clear the tap counter, go to MAC.
  - MAC: 5 cycles, tap counter 0..4, one product accumulated per cycle, then go to WB.
  - WB: 1 cycle. Saturate; shift history (x2<=x1, x1<=x0, y2<=y1, y1<=result). Advance stage, then channel. After the last channel/stage go to DONE, else back to MAC.
  - DONE: 1 cycle. Register sample_out, pulse out_valid, return to IDLE.
- Latency: sample_valid accepted at edge 0 gives out_valid high in cycle CHANNELS*STAGES*6+1 (default 25). Throughput is one sample per 26 cycles. At 144 MHz this leaves ample margin versus a 48 kHz strobe.
- sample_out holds its value until the next DONE.
- sample_valid while not IDLE: sample dropped, overrun set to 1. overrun is cleared only by reset.
- Preset change: if the latched filter_sel differs from the previous accepted sample's select, all history registers are zeroed before the MAC pass. This is a transient-free switch.
- filter_sel >= NUM_SETS: treated as set 0.
- Coefficient writes:
  - Accepted only in IDLE and only when in_ready is high in that same cycle. coeff_ack pulses on the next cycle.
  - Writes in any other state are ignored and produce no ack.
  - Tap addresses 5..7 are ignored and produce no ack.
- Simultaneous coeff_we and sample_valid in IDLE: the write completes first, and the sample uses the new value.

Decomposition:
- Package biquad_pkg:
  - state enum (IDLE, MAC, WB, DONE) and tap enum (B0, B1, B2, A1, A2)
  - localparams ACC_W and UNITY = 2^FRAC
  - function sat_round(acc) returning DATA_W
- Sub-module biquad_coeff_ram:
  - NUM_SETS*STAGES*5 x COEFF_W register file with synchronous write and combinational read
  - reset-to-pass-through loader
  - in/out: clk_144, reset_n, we, waddr, wdata, raddr, rdata

Test Plan:
- Pass-through after reset: sample_in = {1000, -2000}, one strobe -> out_valid in cycle 25, sample_out = {1000, -2000}, in_ready low during cycles 1..25.
- Gain/rounding: set 1, stage 0, b0 = 2^29 (0.5); filter_sel = 1; input 3 -> output 2 (round half up). Input -3 -> output -1.
- Saturation: b0 = 1.5*2^30 on both stages; input 30000 -> output 32767. Input -30000 -> output -32768.
- Recursion: stage 0 with b0 = 2^30, a1 = 2^29; impulse 1024 then zeros -> outputs 1024, 512, 256, 128 on successive out_valid pulses.
- Overrun and preset switch: strobe at cycle 0 and cycle 5 -> one out_valid, overrun = 1. Then change filter_sel -> history cleared, and the first output equals b0*x only.
- Reset mid-operation: reset_n low during MAC -> next cycle in_ready = 1, out_valid = 0, overrun = 0, coefficients back to pass-through.
